// File: rtl/alu_exec_unit.sv
// ---------------------------------------------------------------------------
// alu_exec_unit
// Execution-stage ALU. Simple operations are combinational. Signed multiply
// (and optionally divide) share one iterative engine that does a single
// shift/add (or shift/subtract) step per clock. It writes HI/LO and raises
// Stall until the result is ready.
//
// Optional feature macro: ALU_DIV_EN. Define it to build the signed restoring
// divider. Without it, code 1011 is treated as an unsupported code.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   ALU_Control  4-bit operation code from the ALU control decoder
//   A, B         operands (rs, rt/immediate)
//   Shamt        shift amount for sll/srl/sra
//   Result       operation result
//   Zero         high when Result == 0
//   Stall        high while a mul/div is pending
//   Hi, Lo       HI/LO registers (product halves, or remainder/quotient)
// ---------------------------------------------------------------------------
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       ALU_Control,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [4:0]       Shamt,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic             Stall,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_NOR = 4'b1100;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_SLL = 4'b1000;
    localparam logic [3:0] OP_SRL = 4'b1001;
    localparam logic [3:0] OP_SRA = 4'b1010;
    localparam logic [3:0] OP_MUL = 4'b0101;
`ifdef ALU_DIV_EN
    localparam logic [3:0] OP_DIV = 4'b1011;
`endif

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    // Two's-complement negate when n is set.
    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic n);
        return n ? (~v + WIDTH'(1)) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] cond_neg_w(input logic [2*WIDTH-1:0] v, input logic n);
        return n ? (~v + (2*WIDTH)'(1)) : v;
    endfunction

    // Magnitude of a signed value. The most negative value maps to 2^(WIDTH-1),
    // which still fits because the engine works on unsigned magnitudes.
    function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v);
        return cond_neg(v, v[WIDTH-1]);
    endfunction

    state_t state, state_nxt;

    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] acc;      // product high half / partial remainder
    logic [WIDTH-1:0] mq;       // multiplier / dividend, becomes low half / quotient
    logic [WIDTH-1:0] mcand;    // |B|: multiplicand or divisor
    logic             sign_a;
    logic             sign_b;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    logic is_mul, is_div, is_md;

    logic signed [WIDTH-1:0] a_s, b_s;
    assign a_s = A;
    assign b_s = B;

    assign is_mul = (ALU_Control == OP_MUL);
`ifdef ALU_DIV_EN
    logic op_div;
    logic div_by_zero;
    assign is_div      = (ALU_Control == OP_DIV);
    assign div_by_zero = is_div && (B == '0);
`else
    assign is_div = 1'b0;
`endif
    assign is_md = is_mul || is_div;

    // One multiply step: conditional add of the multiplicand, then shift the
    // {carry, acc, mq} triple right by one.
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_acc, mul_mq;
    assign mul_sum = {1'b0, acc} + (mq[0] ? {1'b0, mcand} : '0);
    assign mul_acc = mul_sum[WIDTH:1];
    assign mul_mq  = {mul_sum[0], mq[WIDTH-1:1]};

    logic [WIDTH-1:0] step_acc, step_mq, fin_hi, fin_lo;

`ifdef ALU_DIV_EN
    // One restoring-divide step: shift the next dividend bit into the partial
    // remainder and subtract the divisor if it fits. When it fits, the true
    // difference is below the divisor, so the low WIDTH bits are exact.
    logic [WIDTH:0]   div_r;
    logic             div_ge;
    logic [WIDTH-1:0] div_acc, div_mq;
    assign div_r   = {acc, mq[WIDTH-1]};
    assign div_ge  = (div_r >= {1'b0, mcand});
    assign div_acc = div_ge ? (div_r[WIDTH-1:0] - mcand) : div_r[WIDTH-1:0];
    assign div_mq  = {mq[WIDTH-2:0], div_ge};

    always_comb begin
        step_acc = op_div ? div_acc : mul_acc;
        step_mq  = op_div ? div_mq  : mul_mq;
        if (op_div) begin
            fin_lo = cond_neg(div_mq, sign_a ^ sign_b);
            fin_hi = cond_neg(div_acc, sign_a);
        end else begin
            {fin_hi, fin_lo} = cond_neg_w({mul_acc, mul_mq}, sign_a ^ sign_b);
        end
    end
`else
    always_comb begin
        step_acc = mul_acc;
        step_mq  = mul_mq;
        {fin_hi, fin_lo} = cond_neg_w({mul_acc, mul_mq}, sign_a ^ sign_b);
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (is_md) begin
`ifdef ALU_DIV_EN
                    state_nxt = div_by_zero ? DONE : BUSY;
`else
                    state_nxt = BUSY;
`endif
                end
            end
            // Dropping the mul/div code mid-operation is a flush.
            BUSY: begin
                if (!is_md)          state_nxt = IDLE;
                else if (cnt == '0)  state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            acc    <= '0;
            mq     <= '0;
            mcand  <= '0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
`ifdef ALU_DIV_EN
            op_div <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (is_md) begin
                        sign_a <= A[WIDTH-1];
                        sign_b <= B[WIDTH-1];
                        mq     <= mag(a_s);
                        mcand  <= mag(b_s);
                        acc    <= '0;
                        cnt    <= CNT_W'(WIDTH-1);
`ifdef ALU_DIV_EN
                        op_div <= is_div;
                        if (div_by_zero) begin
                            hi_q <= A;
                            lo_q <= '1;
                        end
`endif
                    end
                end
                BUSY: begin
                    if (is_md) begin
                        acc <= step_acc;
                        mq  <= step_mq;
                        cnt <= cnt - CNT_W'(1);
                        if (cnt == '0) begin
                            hi_q <= fin_hi;
                            lo_q <= fin_lo;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        Result = '0;
        case (ALU_Control)
            OP_AND: Result = A & B;
            OP_OR:  Result = A | B;
            OP_ADD: Result = A + B;
            OP_SUB: Result = A - B;
            OP_XOR: Result = A ^ B;
            OP_NOR: Result = ~(A | B);
            OP_SLT: Result = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
            OP_SLL: Result = B << Shamt;
            OP_SRL: Result = B >> Shamt;
            OP_SRA: Result = b_s >>> Shamt;
            OP_MUL: Result = (state == DONE) ? lo_q : '0;
`ifdef ALU_DIV_EN
            OP_DIV: Result = (state == DONE) ? lo_q : '0;
`endif
            default: Result = '0;
        endcase
    end

    assign Zero  = (Result == '0);
    assign Stall = is_md && (state != DONE) && !reset;
    assign Hi    = hi_q;
    assign Lo    = lo_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;

    localparam logic [3:0] C_AND = 4'b0000;
    localparam logic [3:0] C_OR  = 4'b0001;
    localparam logic [3:0] C_ADD = 4'b0010;
    localparam logic [3:0] C_SUB = 4'b0110;
    localparam logic [3:0] C_XOR = 4'b0100;
    localparam logic [3:0] C_NOR = 4'b1100;
    localparam logic [3:0] C_SLT = 4'b0111;
    localparam logic [3:0] C_SLL = 4'b1000;
    localparam logic [3:0] C_SRL = 4'b1001;
    localparam logic [3:0] C_SRA = 4'b1010;
    localparam logic [3:0] C_MUL = 4'b0101;
    localparam logic [3:0] C_DIV = 4'b1011;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  ALU_Control;
    logic [31:0] A, B;
    logic [4:0]  Shamt;
    logic [31:0] Result, Hi, Lo;
    logic        Zero, Stall;

    always #5 clk = ~clk;

    alu_exec_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .ALU_Control(ALU_Control),
        .A(A), .B(B), .Shamt(Shamt),
        .Result(Result), .Zero(Zero), .Stall(Stall), .Hi(Hi), .Lo(Lo)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    typedef struct {
        string       tag;
        logic [31:0] res;
        logic [31:0] hi;
        logic [31:0] lo;
        int          stalls;
    } exp_t;

    exp_t sbq[$];

    // Reference HI/LO as the architecture should see them.
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    function automatic void push_exp(input string tag, input logic [3:0] code,
                                     input logic [31:0] a, input logic [31:0] b,
                                     input logic [4:0] sh);
        exp_t e;
        logic signed [31:0] sa, sb;
        logic signed [63:0] pa, pb, p;
        sa = a;
        sb = b;
        e.tag    = tag;
        e.stalls = 0;
        e.res    = '0;
        case (code)
            C_AND: e.res = a & b;
            C_OR:  e.res = a | b;
            C_ADD: e.res = a + b;
            C_SUB: e.res = a - b;
            C_XOR: e.res = a ^ b;
            C_NOR: e.res = ~(a | b);
            C_SLT: e.res = (sa < sb) ? 32'd1 : 32'd0;
            C_SLL: e.res = b << sh;
            C_SRL: e.res = b >> sh;
            C_SRA: e.res = sb >>> sh;
            C_MUL: begin
                pa = {{32{a[31]}}, a};
                pb = {{32{b[31]}}, b};
                p  = pa * pb;
                m_hi = p[63:32];
                m_lo = p[31:0];
                e.res = m_lo;
                e.stalls = 33;
            end
`ifdef ALU_DIV_EN
            C_DIV: begin
                if (b == '0) begin
                    m_lo = '1;
                    m_hi = a;
                    e.stalls = 1;
                end else begin
                    m_lo = sa / sb;
                    m_hi = sa % sb;
                    e.stalls = 33;
                end
                e.res = m_lo;
            end
`endif
            default: e.res = '0;
        endcase
        e.hi = m_hi;
        e.lo = m_lo;
        sbq.push_back(e);
    endfunction

    // Present one operation at the start of a cycle, count stalled cycles,
    // then compare against the scoreboard in the first non-stalled cycle.
    task automatic run_op(input string tag, input logic [3:0] code,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] sh, input bit perturb);
        exp_t e;
        int   stalls;
        @(posedge clk);
        #1;
        ALU_Control = code;
        A = a;
        B = b;
        Shamt = sh;
        push_exp(tag, code, a, b, sh);
        stalls = 0;
        @(negedge clk);
        if (Stall) chk({tag, "_pending_res"}, Result, 32'h0);
        while (Stall && stalls < 200) begin
            stalls++;
            if (perturb && stalls == 3) begin
                A = 32'h0000_1234;
                B = 32'h0000_0777;
            end
            @(negedge clk);
        end
        if (sbq.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sbq.pop_front();
            chk({e.tag, "_stalls"}, 32'(stalls), 32'(e.stalls));
            chk({e.tag, "_res"}, Result, e.res);
            chk({e.tag, "_zero"}, 32'(Zero), 32'(e.res == 32'h0));
            chk({e.tag, "_hi"}, Hi, e.hi);
            chk({e.tag, "_lo"}, Lo, e.lo);
        end
    endtask

    initial begin
        reset = 1'b1;
        ALU_Control = C_MUL;
        A = 32'hFFFF_FFFD;
        B = 32'd7;
        Shamt = '0;
        #2;
        chk("rst_stall", 32'(Stall), 32'd0);
        chk("rst_hi", Hi, 32'h0);
        chk("rst_lo", Lo, 32'h0);
        ALU_Control = C_ADD;
        A = 32'd2;
        B = 32'd3;
        #1;
        chk("rst_comb_add", Result, 32'd5);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        run_op("add", C_ADD, 32'h0000_000F, 32'h0000_00F0, 5'd0, 1'b0);
        run_op("sub", C_SUB, 32'h0000_000F, 32'h0000_00F0, 5'd0, 1'b0);
        run_op("and", C_AND, 32'h0000_000F, 32'h0000_00F0, 5'd0, 1'b0);
        run_op("or",  C_OR,  32'h0000_000F, 32'h0000_00F0, 5'd0, 1'b0);
        run_op("nor", C_NOR, 32'h0000_000F, 32'h0000_00F0, 5'd0, 1'b0);
        run_op("xor", C_XOR, 32'h0000_00FF, 32'h0000_0F0F, 5'd0, 1'b0);
        run_op("add_wrap", C_ADD, 32'hFFFF_FFFF, 32'h0000_0002, 5'd0, 1'b0);
        run_op("sll", C_SLL, 32'h0, 32'h8000_0000, 5'd4, 1'b0);
        run_op("srl", C_SRL, 32'h0, 32'h8000_0000, 5'd4, 1'b0);
        run_op("sra", C_SRA, 32'h0, 32'h8000_0000, 5'd4, 1'b0);
        run_op("slt_neg", C_SLT, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0, 1'b0);
        run_op("slt_pos", C_SLT, 32'h0000_0001, 32'hFFFF_FFFF, 5'd0, 1'b0);
        run_op("bad_0011", 4'b0011, 32'h1234_5678, 32'h1, 5'd0, 1'b0);
        run_op("bad_1111", 4'b1111, 32'h1234_5678, 32'h1, 5'd0, 1'b0);

        run_op("mul_m3x7", C_MUL, 32'hFFFF_FFFD, 32'd7, 5'd0, 1'b1);
        run_op("mul_b2b", C_MUL, 32'hFFFF_FFFD, 32'd7, 5'd0, 1'b0);
        run_op("mul_minmin", C_MUL, 32'h8000_0000, 32'h8000_0000, 5'd0, 1'b0);
        run_op("mul_maxneg", C_MUL, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 5'd0, 1'b0);
        run_op("add_keep", C_ADD, 32'd1, 32'd1, 5'd0, 1'b0);

        run_op("div_m7d2", C_DIV, 32'hFFFF_FFF9, 32'd2, 5'd0, 1'b0);
        run_op("div_5d0", C_DIV, 32'd5, 32'd0, 5'd0, 1'b0);
        run_op("div_100dm7", C_DIV, 32'd100, 32'hFFFF_FFF9, 5'd0, 1'b0);
        run_op("div_mind3", C_DIV, 32'h8000_0000, 32'd3, 5'd0, 1'b0);

        // Reset during cycle 10 of a multiply.
        @(posedge clk);
        #1;
        ALU_Control = C_MUL;
        A = 32'hFFFF_FFFD;
        B = 32'd7;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("rst_mid_stall", 32'(Stall), 32'd0);
        chk("rst_mid_hi", Hi, 32'h0);
        chk("rst_mid_lo", Lo, 32'h0);
        m_hi = '0;
        m_lo = '0;
        @(posedge clk);
        #1;
        ALU_Control = C_ADD;
        reset = 1'b0;
        run_op("mul_6x7", C_MUL, 32'd6, 32'd7, 5'd0, 1'b0);

        // Flush: drop the mul code part-way through BUSY.
        @(posedge clk);
        #1;
        ALU_Control = C_MUL;
        A = 32'd100;
        B = 32'd200;
        repeat (5) @(posedge clk);
        #1;
        ALU_Control = C_ADD;
        A = 32'h10;
        B = 32'h20;
        #1;
        chk("flush_res", Result, 32'h30);
        chk("flush_stall", 32'(Stall), 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk("flush_hi", Hi, m_hi);
        chk("flush_lo", Lo, m_lo);
        run_op("mul_after_flush", C_MUL, 32'hFFFF_FFF6, 32'hFFFF_FFF5, 5'd0, 1'b0);
        run_op("add_end", C_ADD, 32'd0, 32'd0, 5'd0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
